// File: rtl/rst_seq_gen.sv
// Reset sequencer: synchronizes Rst_i release, holds all channels, then releases them one by one.
// Optional synchronous software reset (SwRst_i) is built only when RST_SEQ_SWRST_EN is defined.
module rst_seq_gen #(
  parameter int N_CH           = 4,
  parameter int SYNC_STAGES    = 2,
  parameter int HOLD_CYCLES    = 16,
  parameter int STAGGER_CYCLES = 4
) (
  input  logic            Clk_i,
  input  logic            Rst_i,
`ifdef RST_SEQ_SWRST_EN
  input  logic            SwRst_i,
`endif
  output logic [N_CH-1:0] Rst_o,
  output logic [N_CH-1:0] RstN_o,
  output logic            Busy_o,
  output logic [2:0]      State_o
);

  localparam int CNT_MAX = (HOLD_CYCLES > STAGGER_CYCLES) ? HOLD_CYCLES : STAGGER_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam int IW      = (N_CH > 1) ? $clog2(N_CH) : 1;
  // The FSM state flop acts as the last synchronizer stage, so the chain is one shorter.
  localparam int SW      = SYNC_STAGES - 1;

  localparam logic [CW-1:0]   HOLD_LAST = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0]   STG_LAST  = (STAGGER_CYCLES > 0) ? CW'(STAGGER_CYCLES - 1) : '0;
  localparam logic [IW-1:0]   LAST_CH   = IW'(N_CH - 1);
  localparam logic [N_CH-1:0] CH0       = N_CH'(1);

  typedef enum logic [2:0] {
    ST_ASSERT  = 3'd0,
    ST_SYNC    = 3'd1,
    ST_HOLD    = 3'd2,
    ST_RELEASE = 3'd3,
    ST_RUN     = 3'd4
  } state_t;

  state_t          state_q;
  logic [SW-1:0]   sync_q;
  logic [CW-1:0]   cnt_q;
  logic [IW-1:0]   ch_idx_q;
  logic [N_CH-1:0] rst_q;
  logic [N_CH-1:0] rstn_q;
  logic            busy_q;
  logic            sw_req;

`ifdef RST_SEQ_SWRST_EN
  assign sw_req = SwRst_i;
`else
  assign sw_req = 1'b0;
`endif

  always_ff @(posedge Clk_i or posedge Rst_i) begin
    if (Rst_i) begin
      sync_q <= '0;
    end else begin
      sync_q <= (sync_q << 1) | SW'(1);
    end
  end

  always_ff @(posedge Clk_i or posedge Rst_i) begin
    if (Rst_i) begin
      state_q  <= ST_ASSERT;
      rst_q    <= '1;
      rstn_q   <= '0;
      busy_q   <= 1'b1;
      cnt_q    <= '0;
      ch_idx_q <= '0;
    end else if (sw_req && (state_q == ST_HOLD || state_q == ST_RELEASE || state_q == ST_RUN)) begin
      // Software reset re-enters HOLD directly; Rst_i is already synchronized here.
      state_q  <= ST_HOLD;
      rst_q    <= '1;
      rstn_q   <= '0;
      busy_q   <= 1'b1;
      cnt_q    <= '0;
      ch_idx_q <= '0;
    end else begin
      case (state_q)
        ST_ASSERT, ST_SYNC: begin
          cnt_q   <= '0;
          state_q <= sync_q[SW-1] ? ST_HOLD : ST_SYNC;
        end
        ST_HOLD: begin
          if (cnt_q == HOLD_LAST) begin
            cnt_q <= '0;
            if (N_CH == 1 || STAGGER_CYCLES == 0) begin
              rst_q   <= '0;
              rstn_q  <= '1;
              busy_q  <= 1'b0;
              state_q <= ST_RUN;
            end else begin
              rst_q    <= rst_q & ~CH0;
              rstn_q   <= rstn_q | CH0;
              ch_idx_q <= IW'(1);
              state_q  <= ST_RELEASE;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_RELEASE: begin
          if (cnt_q == STG_LAST) begin
            cnt_q  <= '0;
            rst_q  <= rst_q & ~(CH0 << ch_idx_q);
            rstn_q <= rstn_q | (CH0 << ch_idx_q);
            if (ch_idx_q == LAST_CH) begin
              busy_q  <= 1'b0;
              state_q <= ST_RUN;
            end else begin
              ch_idx_q <= ch_idx_q + 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_RUN: begin
          cnt_q <= '0;
        end
        default: begin
          state_q <= ST_ASSERT;
          rst_q   <= '1;
          rstn_q  <= '0;
          busy_q  <= 1'b1;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign Rst_o   = rst_q;
  assign RstN_o  = rstn_q;
  assign Busy_o  = busy_q;
  assign State_o = state_q;

endmodule
